// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE
  } arb_state_t;

  localparam int unsigned UART_DATA_W       = 8;
  localparam int unsigned UART_BUSY_TIMEOUT = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or after rr_ptr, wrapping.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] win,
  output logic               valid
);

  logic found;

  // Two passes: indices at/above the pointer first, then the wrapped lower ones.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i] && (i >= 32'(rr_ptr))) begin
        win[i] = 1'b1;
        found  = 1'b1;
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i]) begin
        win[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end

  assign valid = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ clients.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned DATA_W       = UART_DATA_W,
  parameter int unsigned BUSY_TIMEOUT = UART_BUSY_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        done,
  input  logic                      tx_ready,
  output logic                      tx_send,
  output logic [DATA_W-1:0]         tx_data,
  output logic                      busy,
  output logic                      err_timeout
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(BUSY_TIMEOUT + 1);

  arb_state_t          state, state_next;
  logic [PTR_W-1:0]    rr_ptr, rr_ptr_next, owner;
  logic [CNT_W-1:0]    cnt, cnt_next;
  logic [NUM_REQ-1:0]  win, grant_next, done_next;
  logic                valid;
  logic [DATA_W-1:0]   win_data, tx_data_next;
  logic                tx_send_next, err_next, busy_next;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .win    (win),
    .valid  (valid)
  );

  always_comb begin
    win_data = '0;
    owner    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win[i])   win_data = req_data[i*DATA_W +: DATA_W];
      if (grant[i]) owner    = PTR_W'(i);
    end
  end

  always_comb begin
    state_next   = state;
    grant_next   = grant;
    tx_data_next = tx_data;
    done_next    = '0;
    tx_send_next = 1'b0;
    err_next     = 1'b0;
    rr_ptr_next  = rr_ptr;
    cnt_next     = cnt;
    case (state)
      IDLE: begin
        if (tx_ready && valid) begin
          grant_next   = win;
          tx_data_next = win_data;
          state_next   = ISSUE;
        end
      end
      ISSUE: begin
        tx_send_next = 1'b1;
        cnt_next     = '0;
        state_next   = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!tx_ready) begin
          state_next = WAIT_DONE;
        end else begin
          if (cnt != CNT_W'(BUSY_TIMEOUT)) cnt_next = cnt + 1'b1;
          // Counter hits BUSY_TIMEOUT on this edge; the pulse lands on that cycle.
          if (cnt == CNT_W'(BUSY_TIMEOUT - 1)) begin
            err_next   = 1'b1;
            grant_next = '0;
            state_next = IDLE;
          end
        end
      end
      WAIT_DONE: begin
        if (tx_ready) begin
          done_next   = grant;
          grant_next  = '0;
          rr_ptr_next = (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      grant       <= '0;
      done        <= '0;
      tx_send     <= 1'b0;
      tx_data     <= '0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
      rr_ptr      <= '0;
      cnt         <= '0;
    end else begin
      state       <= state_next;
      grant       <= grant_next;
      done        <= done_next;
      tx_send     <= tx_send_next;
      tx_data     <= tx_data_next;
      busy        <= busy_next;
      err_timeout <= err_next;
      rr_ptr      <= rr_ptr_next;
      cnt         <= cnt_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter; the bench plays the transmitter.
module tb_uart_tx_arbiter;

  localparam int unsigned BT = 8;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic        tx_ready;
  logic        tx_send;
  logic [7:0]  tx_data;
  logic        busy;
  logic        err_timeout;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  uart_tx_arbiter #(
    .NUM_REQ      (4),
    .DATA_W       (8),
    .BUSY_TIMEOUT (BT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_data    (req_data),
    .grant       (grant),
    .done        (done),
    .tx_ready    (tx_ready),
    .tx_send     (tx_send),
    .tx_data     (tx_data),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_grant"}, 32'(grant), 32'h0);
    check({tag, "_done"}, 32'(done), 32'h0);
    check({tag, "_tx_send"}, 32'(tx_send), 32'h0);
    check({tag, "_tx_data"}, 32'(tx_data), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_err"}, 32'(err_timeout), 32'h0);
  endtask

  // One full transaction from IDLE with a request already presented and tx_ready=1.
  task automatic run_txn(input logic [3:0] exp_grant, input logic [7:0] exp_data,
                         input int unsigned frame, input bit alter,
                         input logic [3:0] alt_req, input logic [31:0] alt_data);
    tick();
    check("grant", 32'(grant), 32'(exp_grant));
    check("tx_data", 32'(tx_data), 32'(exp_data));
    check("tx_send_pre", 32'(tx_send), 32'h0);
    check("done_clear", 32'(done), 32'h0);
    check("busy_on", 32'(busy), 32'h1);
    tick();
    check("tx_send", 32'(tx_send), 32'h1);
    check("grant_issue", 32'(grant), 32'(exp_grant));
    tick();
    check("tx_send_once", 32'(tx_send), 32'h0);
    tx_ready = 1'b0;
    for (int unsigned f = 0; f < frame; f++) begin
      tick();
      if (alter && f == 0) begin
        req      = alt_req;
        req_data = alt_data;
      end
      check("grant_hold", 32'(grant), 32'(exp_grant));
      check("data_hold", 32'(tx_data), 32'(exp_data));
      check("done_early", 32'(done), 32'h0);
    end
    tx_ready = 1'b1;
    tick();
    check("done", 32'(done), 32'(exp_grant));
    check("grant_cleared", 32'(grant), 32'h0);
    check("busy_off", 32'(busy), 32'h0);
    check("tx_send_idle", 32'(tx_send), 32'h0);
  endtask

  initial begin
    reset    = 1'b0;
    tx_ready = 1'b1;
    req      = 4'b1111;
    req_data = 32'h44_33_22_11;
    tick();
    tick();
    check_all_zero("reset");
    reset = 1'b1;

    // All clients requesting from reset: 0,1,2,3,0
    run_txn(4'b0001, 8'h11, 3, 1'b0, 4'b0, 32'h0);
    run_txn(4'b0010, 8'h22, 3, 1'b0, 4'b0, 32'h0);
    run_txn(4'b0100, 8'h33, 3, 1'b0, 4'b0, 32'h0);
    run_txn(4'b1000, 8'h44, 3, 1'b0, 4'b0, 32'h0);
    run_txn(4'b0001, 8'h11, 3, 1'b0, 4'b0, 32'h0);

    // Single request from client 2 (pointer now 1)
    req      = 4'b0100;
    req_data = 32'h00_A5_00_00;
    run_txn(4'b0100, 8'hA5, 4, 1'b0, 4'b0, 32'h0);

    // Wrap-around: pointer 3, clients 3 and 0
    req      = 4'b1001;
    req_data = 32'h3C_00_00_C0;
    run_txn(4'b1000, 8'h3C, 2, 1'b0, 4'b0, 32'h0);
    req = 4'b0001;
    run_txn(4'b0001, 8'hC0, 2, 1'b0, 4'b0, 32'h0);

    // Request and data change during WAIT_DONE are ignored
    req      = 4'b0010;
    req_data = 32'h00_00_5A_00;
    run_txn(4'b0010, 8'h5A, 3, 1'b1, 4'b0000, 32'h00_00_FF_00);
    check("idle_after_drop", 32'(grant), 32'h0);

    // Transmitter stuck: tx_ready never falls (pointer now 2)
    req      = 4'b0100;
    req_data = 32'h44_77_22_11;
    tick();
    check("stuck_grant", 32'(grant), 32'h4);
    tick();
    check("stuck_send", 32'(tx_send), 32'h1);
    for (int unsigned k = 1; k < BT; k++) begin
      tick();
      check("stuck_no_err", 32'(err_timeout), 32'h0);
      check("stuck_grant_hold", 32'(grant), 32'h4);
      check("stuck_no_send", 32'(tx_send), 32'h0);
    end
    tick();
    check("timeout_err", 32'(err_timeout), 32'h1);
    check("timeout_grant", 32'(grant), 32'h0);
    check("timeout_no_done", 32'(done), 32'h0);
    check("timeout_busy", 32'(busy), 32'h0);
    req = 4'b1111;
    tick();
    check("timeout_ptr_kept", 32'(grant), 32'h4);
    check("timeout_err_once", 32'(err_timeout), 32'h0);
    check("regrant_data", 32'(tx_data), 32'h77);

    // Reset during WAIT_DONE aborts at once
    tick();
    check("rst_txn_send", 32'(tx_send), 32'h1);
    tick();
    tx_ready = 1'b0;
    tick();
    tick();
    check("rst_txn_owner", 32'(grant), 32'h4);
    #2 reset = 1'b0;
    #1 check_all_zero("async_reset");
    tick();
    check_all_zero("reset_held");
    tx_ready = 1'b1;
    reset    = 1'b1;
    run_txn(4'b0001, 8'h11, 2, 1'b0, 4'b0, 32'h0);
    req = 4'b0000;
    tick();
    check("final_done_clear", 32'(done), 32'h0);
    check("final_idle", 32'(grant), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one UART transmitter between `NUM_REQ` byte-producing clients. It drives the transmitter's send strobe and parallel data word, tracks the transmitter's ready level to detect when the frame starts and finishes, and returns a per-client completion pulse. The block sits between the client logic and the UART Tx controller and its TX shift register. It is the only block that issues send commands to that transmitter.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `DATA_W`, 8: byte width driven to the TX shift register.
- `BUSY_TIMEOUT`, 8: maximum cycles allowed for `tx_ready` to fall after `tx_send`.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-low reset.
- `req`  in  `NUM_REQ`  per-client transmit request, level.
- `req_data`  in  `NUM_REQ*DATA_W`  client bytes; client i occupies bits [i*DATA_W +: DATA_W].
- `grant`  out  `NUM_REQ`  one-hot owner of the current transaction.
- `done`  out  `NUM_REQ`  one-cycle completion pulse to the owner.
- `tx_ready`  in  1  transmitter ready level; high when the transmitter is idle or has finished a frame.
- `tx_send`  out  1  one-cycle send strobe to the transmitter.
- `tx_data`  out  `DATA_W`  registered byte for the TX shift register load.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `err_timeout`  out  1  one-cycle pulse when the transmitter fails to start.

## Operation
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- **IDLE**: when `tx_ready`=1 and `req`≠0, pick a winner by round-robin.
  - The search starts at `rr_ptr` and wraps modulo `NUM_REQ`.
  - Register `grant` to the winner's one-hot code and `tx_data` to the winner's byte; go to ISSUE.
  - If `tx_ready`=0 while in IDLE, no grant is issued.
- **ISSUE**: assert `tx_send` for exactly one cycle, then go to WAIT_BUSY and clear the timeout counter.
- **WAIT_BUSY**: wait for `tx_ready`=0.
  - `tx_ready`=0 → go to WAIT_DONE.
  - Counter reaches `BUSY_TIMEOUT` → pulse `err_timeout`, clear `grant`, leave `rr_ptr` unchanged, go to IDLE. No `done` pulse.
- **WAIT_DONE**: wait for `tx_ready`=1.
  - On `tx_ready`=1, pulse `done` for the owner bit and clear `grant`.
  - Set `rr_ptr` to (owner+1) mod `NUM_REQ`; go to IDLE.
- `tx_data` and `grant` stay stable from ISSUE through the last WAIT_DONE cycle.
- Changes to `req` or `req_data` after the grant are ignored. The committed byte is sent.
- A client that keeps `req` high after `done` is treated as a new request. It ranks lowest in the next arbitration.
- Timeout counter width is $clog2(`BUSY_TIMEOUT`+1) and saturates at `BUSY_TIMEOUT`.

## Timing
- Reset values: `grant`=0, `done`=0, `tx_send`=0, `tx_data`=0, `busy`=0, `err_timeout`=0, `rr_ptr`=0, state IDLE.
- Reset asserted mid-transaction aborts immediately, with no `done` and no error pulse.
- Latency from `req` (sampled in IDLE) to `grant`/`tx_data` valid is 1 cycle. `tx_send` is high in the cycle after the grant registers.
- The transmitter's ready level drops 1 cycle after it samples `tx_send`, so WAIT_BUSY normally lasts 1 cycle.
- `done` is asserted in the cycle after `tx_ready` is sampled high in WAIT_DONE, together with `grant` clearing.
- The earliest next grant is 1 cycle after `done`. Back-to-back throughput is frame time + 4 cycles.
- All outputs are registered. `tx_send` never asserts while `grant`=0.

## Structure
- Shared package `uart_pkg` holds:
  - the FSM state enum `arb_state_t`;
  - the default `DATA_W`;
  - the `BUSY_TIMEOUT` default constant.
- Natural sub-module: `rr_pick`. It is combinational; inputs are `req` and `rr_ptr`, outputs are a one-hot winner and a valid flag.
- The pointer register and the FSM stay in `uart_tx_arbiter`.

## Test plan
- Single request: `req`=0100 with byte 0xA5, `tx_ready`=1.
  - Expect `grant`=0100 and `tx_data`=0xA5 after 1 cycle, then one `tx_send` pulse.
  - Expect `done`=0100 after the transmitter's ready level returns, and `rr_ptr`=3.
- All request: `req`=1111 held high continuously from reset.
  - Grants are serviced in order 0,1,2,3,0.
  - Each `done` precedes the next `grant`, and there is no overlap.
- Wrap-around: `rr_ptr`=3 with `req`=1001 → client 3 is granted first, then client 0.
- Data change: alter `req_data` and drop `req` during WAIT_DONE → `tx_data` is unchanged and `done` still pulses.
- Transmitter stuck: hold `tx_ready`=1 after `tx_send`.
  - Expect `err_timeout` to pulse exactly `BUSY_TIMEOUT` cycles after WAIT_BUSY entry.
  - Expect `grant` cleared, no `done`, and `rr_ptr` unchanged.
- Reset during WAIT_DONE: assert `reset`=0 → all outputs are 0 immediately. After release, a new request is serviced from `rr_ptr`=0.
